// File: rtl/run_ctrl.sv
// Run-enable controller for the ch5 even-step counter.
// Two raw pushbuttons are synchronized and debounced, then turned into
// single-cycle presses that drive a 3-state IDLE/RUN/STEP FSM.

// Per-button synchronizer, debouncer and rising-edge press detector.
module run_ctrl_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1, s2, deb, deb_q;
  logic [CW-1:0] cnt;

  // Two-flop sync, then the level must disagree for DEB_CYCLES edges to flip deb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      if (s2 != deb) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // One pulse per rising edge of the debounced level; a held button never repeats.
  assign press = deb & ~deb_q;
endmodule

module run_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int LAP_LEN    = 8,
  parameter int AUTO_STOP  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic run,
  output logic running,
  output logic lap_done
);
  localparam int NUM_BTN = 2;
  localparam int LW      = (LAP_LEN > 1) ? $clog2(LAP_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  logic [NUM_BTN-1:0] raw, press;
  logic               run_press, step_press;
  state_t             state, state_nxt;
  logic [LW-1:0]      lap_cnt;
  logic               lap_end;

  // Bit 0 is the run/stop button, bit 1 the single-step button.
  assign raw = {btn_step, btn_run};

  run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw),
    .press (press)
  );

  assign run_press  = press[0];
  assign step_press = press[1];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; run beats step in IDLE, presses are ignored in STEP.
  always_comb begin
    state_nxt = state;
    lap_end   = 1'b0;
    case (state)
      IDLE: begin
        if (run_press)       state_nxt = RUN;
        else if (step_press) state_nxt = STEP;
      end
      RUN: begin
        lap_end = (AUTO_STOP != 0) && (lap_cnt == LW'(LAP_LEN - 1));
        if (run_press || lap_end) state_nxt = IDLE;
      end
      STEP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lap counter clears on RUN entry and counts RUN cycles; lap_done is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_cnt  <= '0;
      lap_done <= 1'b0;
    end else begin
      lap_done <= lap_end;
      if (state == IDLE && run_press) lap_cnt <= '0;
      else if (state == RUN)          lap_cnt <= lap_cnt + LW'(1);
    end
  end

  assign run     = (state == RUN) || (state == STEP);
  assign running = (state == RUN);
endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a vector table for debounce/toggle/step
// behaviour plus hand sequences for auto-stop, simultaneous presses and reset.
module tb_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic run_a, running_a, lap_a;
  logic run_b, running_b, lap_b;
  logic [3:0] cnt_a, cnt_b;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic r;
    logic br;
    logic bs;
    int   cyc;
    logic e_run;
    logic e_running;
    int   e_cnt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  run_ctrl u_dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .run(run_a), .running(running_a), .lap_done(lap_a)
  );

  run_ctrl #(.DEB_CYCLES(4), .LAP_LEN(8), .AUTO_STOP(1)) u_auto (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .run(run_b), .running(running_b), .lap_done(lap_b)
  );

  // Downstream even-step counters (0,2,..,14) advanced by each DUT's run.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a <= 4'd0;
      cnt_b <= 4'd0;
    end else begin
      if (run_a) cnt_a <= cnt_a + 4'd2;
      if (run_b) cnt_b <= cnt_b + 4'd2;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic br, input logic bs, input int cyc,
                              input logic e_run, input logic e_running, input int e_cnt);
    vec_t v;
    v = '{r, br, bs, cyc, e_run, e_running, e_cnt};
    tbl.push_back(v);
  endfunction

  initial begin
    int highs, laps, overlap, first;

    // Reset state, during and after reset.
    tick(2);
    check("rst run", run_a, 0);
    check("rst running", running_a, 0);
    check("rst lap_done", lap_b, 0);
    check("rst run auto", run_b, 0);
    rst = 1'b1;
    tick(5);
    check("post-rst run", run_a, 0);
    check("post-rst running", running_a, 0);
    check("post-rst lap_done", lap_b, 0);

    // Run/stop toggle: press lands on the 7th edge after the raw rise.
    add(1, 1, 0, 6,  0, 0, -1);
    add(1, 1, 0, 1,  1, 1, -1);
    add(1, 1, 0, 13, 1, 1, -1);
    add(1, 0, 0, 20, 1, 1, -1);
    add(1, 1, 0, 6,  1, 1, -1);
    add(1, 1, 0, 1,  0, 0, -1);
    add(1, 1, 0, 13, 0, 0, -1);
    add(1, 0, 0, 20, 0, 0, -1);
    // Glitches 1..3 cycles wide never register.
    for (int w = 1; w <= 3; w++) begin
      add(1, 1, 0, w,  0, 0, -1);
      add(1, 0, 0, 10, 0, 0, -1);
    end
    // Reset, then three single steps advance the counter by 2 each.
    add(0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 0, 2, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      add(1, 0, 1, 6,  0, 0, 2 * (k - 1));
      add(1, 0, 1, 1,  1, 0, 2 * (k - 1));
      add(1, 0, 1, 1,  0, 0, 2 * k);
      add(1, 0, 0, 12, 0, 0, 2 * k);
    end

    foreach (tbl[i]) begin
      rst      = tbl[i].r;
      btn_run  = tbl[i].br;
      btn_step = tbl[i].bs;
      tick(tbl[i].cyc);
      check($sformatf("vec%0d run", i), run_a, tbl[i].e_run);
      check($sformatf("vec%0d running", i), running_a, tbl[i].e_running);
      check($sformatf("vec%0d lap_done", i), lap_a, 0);
      if (tbl[i].e_cnt >= 0) check($sformatf("vec%0d counter", i), cnt_a, tbl[i].e_cnt);
    end

    // Auto-stop lap: run high exactly 8 cycles, one lap_done pulse after it.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    btn_run = 1'b1;
    highs = 0; laps = 0; overlap = 0; first = -1;
    for (int c = 0; c < 40; c++) begin
      if (c == 20) btn_run = 1'b0;
      tick(1);
      if (run_b) begin
        highs++;
        if (first < 0) first = c;
      end
      if (lap_b) begin
        laps++;
        if (run_b) overlap++;
      end
    end
    check("auto first run edge", first, 6);
    check("auto run cycles", highs, 8);
    check("auto lap pulses", laps, 1);
    check("auto lap overlaps run", overlap, 0);
    check("auto running after lap", running_b, 0);
    check("auto counter wrapped", cnt_b, 0);
    check("no-auto still running", running_a, 1);

    // Simultaneous run+step presses: run wins, step dropped.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    btn_run = 1'b1;
    btn_step = 1'b1;
    tick(7);
    check("both run", run_a, 1);
    check("both running", running_a, 1);
    tick(1);
    check("both still running", running_a, 1);
    check("both counter", cnt_a, 2);
    btn_run = 1'b0;
    btn_step = 1'b0;
    tick(10);
    check("both running after release", running_a, 1);

    // Async reset mid-RUN with the run button held through reset.
    btn_run = 1'b1;
    rst = 1'b0;
    #1;
    check("async rst run", run_a, 0);
    check("async rst running", running_a, 0);
    tick(3);
    check("held in rst run", run_a, 0);
    rst = 1'b1;
    tick(6);
    check("held after rst early", run_a, 0);
    tick(1);
    check("held after rst press", run_a, 1);
    check("held after rst running", running_a, 1);
    btn_run = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
